// File: rtl/digit_seq_pkg.sv
// Shared types and the reference digit pattern for the digit sequence generator/detector pair.
package digit_seq_pkg;

    typedef logic [3:0] digit_t;

    // State index equals the number of pattern digits currently matched.
    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} seq_state_t;

    localparam digit_t PATTERN [8] = '{4'd0, 4'd0, 4'd8, 4'd5, 4'd7, 4'd0, 4'd0, 4'd5};

endpackage

// File: rtl/digit_seq_if.sv
// Digit stream input and detector status outputs, grouped for the detector top.
interface digit_seq_if #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned CNT_W   = 8
);

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               match;
    logic [3:0]         progress;
    logic [CNT_W-1:0]   match_count;
    logic               timeout;

    modport master (
        output digit_in, digit_valid,
        input  match, progress, match_count, timeout
    );

    modport slave (
        input  digit_in, digit_valid,
        output match, progress, match_count, timeout
    );

endinterface

// File: rtl/idle_timer.sv
// Idle cycle counter: clears on activity, counts otherwise and parks at TIMEOUT_CYC.
module idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != CntW'(TIMEOUT_CYC)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // High on the edge where the count steps up to TIMEOUT_CYC.
    assign expire = !clear && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_seq_detector.sv
// Overlap-aware detector for the 0,0,8,5,7,0,0,5 digit pattern with a saturating match counter.
// Optional idle timeout enabled by defining DIGIT_SEQ_TIMEOUT_EN.
module digit_seq_detector
    import digit_seq_pkg::*;
#(
    parameter int unsigned SEQ_LEN     = 8,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic        clk,
    input logic        reset,
    digit_seq_if.slave bus
);

    seq_state_t         state_q, state_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DIGIT_W-1:0] digit;
    logic               expire;

    assign digit = bus.digit_in;

`ifdef DIGIT_SEQ_TIMEOUT_EN
    logic timeout_q, timeout_d;

    idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clear (bus.digit_valid),
        .expire(expire)
    );

    assign timeout_d = !bus.digit_valid && expire && (state_q != S0);

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign bus.timeout        = 1'b0;
`endif

    // Fallback targets are the longest pattern prefix that is a suffix of the digits seen.
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (bus.digit_valid) begin
            state_d = S0;
            unique case (state_q)
                S0: if (digit == PATTERN[0]) state_d = S1;
                S1: if (digit == PATTERN[1]) state_d = S2;
                S2: begin
                    if (digit == PATTERN[2])      state_d = S3;
                    else if (digit == PATTERN[0]) state_d = S2;
                end
                S3: begin
                    if (digit == PATTERN[3])      state_d = S4;
                    else if (digit == PATTERN[0]) state_d = S1;
                end
                S4: begin
                    if (digit == PATTERN[4])      state_d = S5;
                    else if (digit == PATTERN[0]) state_d = S1;
                end
                S5: if (digit == PATTERN[5]) state_d = S6;
                S6: if (digit == PATTERN[6]) state_d = S7;
                S7: begin
                    if (digit == PATTERN[SEQ_LEN-1]) match_d = 1'b1;
                    else if (digit == PATTERN[2])    state_d = S3;
                    else if (digit == PATTERN[0])    state_d = S2;
                end
            endcase
        end else if (expire && (state_q != S0)) begin
            state_d = S0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (match_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign bus.match       = match_q;
    assign bus.progress    = 4'(state_q);
    assign bus.match_count = count_q;

endmodule

// File: tb/tb_digit_seq_detector.sv
// Self-checking bench for digit_seq_detector: vector table, directed corner sequences, random stream.
module tb_digit_seq_detector;

    localparam int unsigned TO_CYC = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    digit_seq_if #(.DIGIT_W(4), .CNT_W(8)) bus ();
    digit_seq_if #(.DIGIT_W(4), .CNT_W(2)) bus_sat ();

    assign bus_sat.digit_in    = bus.digit_in;
    assign bus_sat.digit_valid = bus.digit_valid;

    digit_seq_detector #(
        .SEQ_LEN(8), .DIGIT_W(4), .CNT_W(8), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    digit_seq_detector #(
        .SEQ_LEN(8), .DIGIT_W(4), .CNT_W(2), .TIMEOUT_CYC(TO_CYC)
    ) dut_sat (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_sat)
    );

    typedef struct {
        bit       rst;
        bit       vld;
        bit [3:0] d;
        bit       exp_match;
        int       exp_prog;
    } vec_t;

    int total = 0;
    int bad   = 0;

    bit [3:0] pat [8] = '{4'd0, 4'd0, 4'd8, 4'd5, 4'd7, 4'd0, 4'd0, 4'd5};

    // Reference model: recent digit history; progress is the longest suffix that is a prefix.
    int hist [$];
    int m_prog, m_cnt, m_cnt2, m_idle;
    bit m_match, m_to;
    int seen_match, seen_to;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int longest_prefix();
        int n = hist.size();
        for (int k = (n < 7 ? n : 7); k > 0; k--) begin
            bit ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (hist[n-k+i] != int'(pat[i])) ok = 1'b0;
            end
            if (ok) return k;
        end
        return 0;
    endfunction

    function automatic bit full_match();
        if (hist.size() != 8) return 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (hist[i] != int'(pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit [3:0] d);
        m_match = 1'b0;
        m_to    = 1'b0;
        if (r) begin
            hist.delete();
            m_prog = 0;
            m_cnt  = 0;
            m_cnt2 = 0;
            m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            hist.push_back(int'(d));
            if (hist.size() > 8) void'(hist.pop_front());
            if (full_match()) begin
                m_match = 1'b1;
                hist.delete();
                m_prog = 0;
                m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
                m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            end else begin
                m_prog = longest_prefix();
            end
        end else begin
`ifdef DIGIT_SEQ_TIMEOUT_EN
            if (m_idle < int'(TO_CYC)) begin
                m_idle++;
                if (m_idle == int'(TO_CYC) && m_prog != 0) begin
                    m_to = 1'b1;
                    hist.delete();
                    m_prog = 0;
                end
            end
`endif
        end
    endtask

    task automatic apply(input bit r, input bit v, input bit [3:0] d);
        reset           = r;
        bus.digit_valid = v;
        bus.digit_in    = d;
        @(posedge clk);
        model_step(r, v, d);
        #1;
        check("match", int'(bus.match), int'(m_match));
        check("progress", int'(bus.progress), m_prog);
        check("match_count", int'(bus.match_count), m_cnt);
        check("timeout", int'(bus.timeout), int'(m_to));
        check("sat_match", int'(bus_sat.match), int'(m_match));
        check("sat_count", int'(bus_sat.match_count), m_cnt2);
        seen_match += int'(bus.match);
        seen_to    += int'(bus.timeout);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) apply(1'b1, 1'b0, 4'd0);
        seen_match = 0;
        seen_to    = 0;
    endtask

    vec_t vecs [$];
    int   sat_exp [5] = '{1, 2, 3, 3, 3};
    int   gp;

    initial begin
        reset           = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit_in    = 4'd0;

        // Overlap fallback then mid-sequence reset, with hand-derived expectations.
        vecs.push_back('{1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 2});
        vecs.push_back('{0, 1, 8, 0, 3});
        vecs.push_back('{0, 1, 5, 0, 4});
        vecs.push_back('{0, 1, 7, 0, 5});
        vecs.push_back('{0, 1, 0, 0, 6});
        vecs.push_back('{0, 1, 0, 0, 7});
        vecs.push_back('{0, 1, 8, 0, 3});
        vecs.push_back('{0, 1, 5, 0, 4});
        vecs.push_back('{0, 1, 7, 0, 5});
        vecs.push_back('{0, 1, 0, 0, 6});
        vecs.push_back('{0, 1, 0, 0, 7});
        vecs.push_back('{0, 1, 5, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 2});
        vecs.push_back('{0, 1, 8, 0, 3});
        vecs.push_back('{0, 1, 5, 0, 4});
        vecs.push_back('{1, 1, 7, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 2});
        vecs.push_back('{0, 1, 8, 0, 3});
        vecs.push_back('{0, 1, 5, 0, 4});
        vecs.push_back('{0, 1, 7, 0, 5});
        vecs.push_back('{0, 1, 0, 0, 6});
        vecs.push_back('{0, 1, 0, 0, 7});
        vecs.push_back('{0, 1, 5, 1, 0});
        vecs.push_back('{0, 1, 9, 0, 0});
        vecs.push_back('{0, 1, 15, 0, 0});

        // Reset for two cycles, then one pattern with a strobe every 4 clocks.
        do_reset(2);
        check("reset_progress", int'(bus.progress), 0);
        check("reset_count", int'(bus.match_count), 0);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, pat[i]);
            if (i == 7) check("first_match_latency", int'(bus.match), 1);
            for (int j = 0; j < 3; j++) apply(1'b0, 1'b0, 4'd0);
        end
        check("slow_match_pulses", seen_match, 1);
        check("slow_count", int'(bus.match_count), 1);
        check("slow_progress_end", int'(bus.progress), 0);

        // Three back-to-back patterns.
        do_reset(1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, pat[i]);
        end
        apply(1'b0, 1'b0, 4'd0);
        check("stream_match_pulses", seen_match, 3);
        check("stream_count", int'(bus.match_count), 3);

        // Table vectors.
        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].rst, vecs[k].vld, vecs[k].d);
            check("tbl_match", int'(bus.match), int'(vecs[k].exp_match));
            check("tbl_progress", int'(bus.progress), vecs[k].exp_prog);
        end

        // Counter saturation on the 2-bit instance.
        do_reset(1);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, pat[i]);
            check("sat_pulse", int'(bus_sat.match), 1);
            check("sat_count_seq", int'(bus_sat.match_count), sat_exp[p]);
        end
        check("sat_pulses_total", seen_match, 5);

        // Idle after a partial match.
        do_reset(1);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, pat[i]);
        for (int i = 0; i < int'(TO_CYC); i++) apply(1'b0, 1'b0, 4'd0);
`ifdef DIGIT_SEQ_TIMEOUT_EN
        check("to_pulses", seen_to, 1);
        check("to_progress", int'(bus.progress), 0);
`else
        check("to_pulses", seen_to, 0);
        check("to_progress", int'(bus.progress), 3);
`endif

        // Strobe on the would-be expiry edge wins.
        do_reset(1);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, pat[i]);
        for (int i = 0; i < int'(TO_CYC) - 1; i++) apply(1'b0, 1'b0, 4'd0);
        apply(1'b0, 1'b1, pat[3]);
        check("to_race_pulses", seen_to, 0);
        check("to_race_progress", int'(bus.progress), 4);
        for (int i = 4; i < 8; i++) apply(1'b0, 1'b1, pat[i]);
        check("to_race_match", seen_match, 1);

        // Random stream, with quiet phases to exercise the idle path.
        do_reset(1);
        gp = 0;
        for (int c = 0; c < 3000; c++) begin
            bit       r, v;
            bit [3:0] d;
            r = ($urandom_range(0, 299) == 0);
            if (((c / 64) % 4) == 3) v = ($urandom_range(0, 15) == 0);
            else                     v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) begin
                d  = pat[gp];
                gp = (gp + 1) % 8;
            end else begin
                d = 4'($urandom_range(0, 15));
            end
            apply(r, v, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_seq_detector.md
Name: digit_seq_detector

Overview:
- Receive-side checker for the 4-bit digit stream produced by the divided-clock sequence generator.
- Samples one digit per `digit_valid` strobe, all on the single system clock.
- Detects the 8-digit pattern 0,0,8,5,7,0,0,5 with overlap-correct (KMP) fallback, and reports match pulses, progress and a saturating match count.
- Sits beside the generator on the same board clock; the strobe comes from the existing divider edge, synchronised by the integrator.

Parameters:
- SEQ_LEN, 8, pattern length; fixed by the package pattern. Any other value is unsupported.
- DIGIT_W, 4, width of each digit.
- CNT_W, 8, width of match_count.
- TIMEOUT_CYC, 64, idle cycles before abandoning a partial match. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digit_in  in  DIGIT_W  digit sampled when digit_valid=1.
- digit_valid  in  1  one-cycle strobe; digit accepted on the rising clk edge where it is high.
- match  out  1  one-cycle pulse on full pattern detection.
- progress  out  4  digits currently matched, 0..7.
- match_count  out  CNT_W  number of matches; saturates at all-ones.
- timeout  out  1  one-cycle pulse; driven 0 when the optional feature is absent.

Behaviour:
- Reset is synchronous: at a clk edge with reset=1, state=S0, progress=0, match=0, match_count=0, timeout=0.
- Reset wins over a simultaneous digit_valid.
- Reset mid-sequence discards the partial match.
- States S0..S7 hold the number of digits matched. progress equals the state index, registered.
- Transitions occur only on edges where digit_valid=1; otherwise the state holds. d denotes digit_in.
  - S0: d=0 -> S1; else -> S0.
  - S1: d=0 -> S2; else -> S0.
  - S2: d=8 -> S3; d=0 -> S2; else -> S0.
  - S3: d=5 -> S4; d=0 -> S1; else -> S0.
  - S4: d=7 -> S5; d=0 -> S1; else -> S0.
  - S5: d=0 -> S6; else -> S0.
  - S6: d=0 -> S7; else -> S0.
  - S7: d=5 -> S0 with match; d=8 -> S3; d=0 -> S2; else -> S0.
- Match latency: match=1 in the cycle immediately after the accepting edge. Same registered timing as progress.
- Back-to-back valid strobes on every clk are legal. Two consecutive full patterns produce two match pulses 8 strobes apart.
- match_count increments with each match pulse and holds at 2^CNT_W-1.
- Digit values 9..15 are treated as generic mismatches.

Optional Feature:
- Macro: DIGIT_SEQ_TIMEOUT_EN.
- With the macro defined:
  - An idle counter clears on every digit_valid and increments otherwise.
  - When it reaches TIMEOUT_CYC while state!=S0, the state is forced to S0 and timeout pulses 1 cycle.
  - The counter stops at TIMEOUT_CYC until the next valid or reset.
  - A digit_valid in the same cycle as expiry takes priority: the digit is processed normally and there is no timeout pulse.
- Without the macro: no counter, timeout tied to 0, and partial matches wait indefinitely.

Decomposition:
- Package digit_seq_pkg holds:
  - typedef digit_t (logic [3:0]);
  - enum seq_state_t {S0..S7};
  - localparam digit_t PATTERN[8] = '{0,0,8,5,7,0,0,5}.
  - The generator side reuses PATTERN.
- One sub-module, idle_timer (count/clear/expire), is instantiated only under DIGIT_SEQ_TIMEOUT_EN.
- The FSM and counter stay in the top.

Test Plan:
- Reset behaviour: assert reset 2 cycles, then feed strobes every 4 clk with 0,0,8,5,7,0,0,5 -> match=1 exactly once, 1 cycle after the 8th strobe; match_count=1; progress ends 0.
- Continuous stream: feed the pattern continuously 3 times -> 3 match pulses spaced 8 strobes apart; match_count=3.
- Overlap fallback: 0,0,8,5,7,0,0,8,5,7,0,0,5 -> progress reads 3 after the second 8; exactly one match at the final 5.
- Mid-sequence reset: feed 0,0,8,5, assert reset for 1 cycle with digit_valid=1 and d=7 -> progress=0, no match; a subsequent full pattern still matches.
- Saturation: with CNT_W=2, send 5 patterns -> match_count sequence 1,2,3,3,3; match pulses still occur 5 times.
- Timeout (macro on, TIMEOUT_CYC=10): feed 0,0,8, then idle 10 cycles -> timeout pulse, progress=0. Repeat with a strobe landing on the expiry cycle -> no timeout and the digit is processed.
